// File: rtl/a_and_b_checker_pkg.sv
// a_and_b_checker_pkg: shared widths, latency bound and FSM encoding for the a&b result checker.
package a_and_b_checker_pkg;
    localparam int DATA_W_DEF  = 8;
    localparam int CNT_W_DEF   = 16;
    localparam int LATENCY_MAX = 8;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;
endpackage

// File: rtl/a_and_b_checker_if.sv
// a_and_b_checker_if: stimulus/control in and result reporting out of the a&b checker.
interface a_and_b_checker_if
    import a_and_b_checker_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
);
    logic              pi_start;
    logic              pi_clr;
    logic [CNT_W-1:0]  pi_num;
    logic [DATA_W-1:0] pi_a;
    logic [DATA_W-1:0] pi_b;
    logic [DATA_W-1:0] pi_c;
    logic [CNT_W-1:0]  po_pass_cnt;
    logic [CNT_W-1:0]  po_err_cnt;
    logic              po_err;
    logic [DATA_W-1:0] po_first_exp;
    logic [DATA_W-1:0] po_first_got;
    logic              po_busy;
    logic              po_done;

    modport master (
        output pi_start, pi_clr, pi_num, pi_a, pi_b, pi_c,
        input  po_pass_cnt, po_err_cnt, po_err, po_first_exp, po_first_got, po_busy, po_done
    );
    modport slave (
        input  pi_start, pi_clr, pi_num, pi_a, pi_b, pi_c,
        output po_pass_cnt, po_err_cnt, po_err, po_first_exp, po_first_got, po_busy, po_done
    );
endinterface

// File: rtl/a_and_b_exp_pipe.sv
// a_and_b_exp_pipe: LATENCY-deep shift register of {valid, expected} entries with synchronous flush.
module a_and_b_exp_pipe #(
    parameter int DATA_W  = 8,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push_vld,
    input  logic [DATA_W-1:0] push_exp,
    output logic              tail_vld,
    output logic [DATA_W-1:0] tail_exp,
    output logic              pend
);
    logic [LATENCY-1:0]             vld_q, vld_d;
    logic [LATENCY-1:0][DATA_W-1:0] exp_q, exp_d;

    always_comb begin
        vld_d = flush ? '0 : (vld_q << 1) | LATENCY'(push_vld);
        exp_d = flush ? '0 : (exp_q << DATA_W) | (LATENCY*DATA_W)'(push_exp);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            exp_q <= '0;
        end else begin
            vld_q <= vld_d;
            exp_q <= exp_d;
        end
    end

    assign tail_vld = vld_q[LATENCY-1];
    assign tail_exp = exp_q[LATENCY-1];
    // still-valid entries after this edge; the top leaves DRAIN when this drops
    assign pend     = |vld_d;
endmodule

// File: rtl/a_and_b_checker.sv
// a_and_b_checker: predicts a&b, delays it by the DUT latency and scores pi_c against it.
module a_and_b_checker
    import a_and_b_checker_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int LATENCY = 1,
    parameter int CNT_W   = CNT_W_DEF
) (
    input logic              clk,
    input logic              rst_n,
    a_and_b_checker_if.slave bus
);
    localparam int LAT = (LATENCY < 1) ? 1 : (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  num_q, num_d, issue_q, issue_d, issue_nx;
    logic [CNT_W-1:0]  pass_cnt_q, pass_cnt_d, err_cnt_q, err_cnt_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] first_exp_q, first_exp_d, first_got_q, first_got_d;
    logic              start_ok, wipe, push, hit, miss;
    logic              tail_vld, pend;
    logic [DATA_W-1:0] tail_exp;

    a_and_b_exp_pipe #(.DATA_W(DATA_W), .LATENCY(LAT)) u_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (wipe),
        .push_vld (push),
        .push_exp (bus.pi_a & bus.pi_b),
        .tail_vld (tail_vld),
        .tail_exp (tail_exp),
        .pend     (pend)
    );

    // pi_clr outranks start and any compare landing on the same edge
    always_comb begin
        start_ok    = bus.pi_start && (state_q == IDLE || state_q == DONE);
        wipe        = bus.pi_clr || start_ok;
        push        = state_q == RUN;
        hit         = tail_vld && tail_exp == bus.pi_c;
        miss        = tail_vld && tail_exp != bus.pi_c;
        issue_nx    = issue_q + CNT_W'(1);
        state_d     = bus.pi_clr ? IDLE : start_ok ? RUN
                    : (state_q == RUN && num_q != '0 && issue_nx == num_q) ? DRAIN
                    : (state_q == DRAIN && !pend) ? DONE : state_q;
        num_d       = bus.pi_clr ? '0 : start_ok ? bus.pi_num : num_q;
        issue_d     = wipe ? '0 : push ? issue_nx : issue_q;
        pass_cnt_d  = wipe ? '0 : (hit && !(&pass_cnt_q)) ? pass_cnt_q + CNT_W'(1) : pass_cnt_q;
        err_cnt_d   = wipe ? '0 : (miss && !(&err_cnt_q)) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
        err_d       = wipe ? 1'b0 : err_q || miss;
        first_exp_d = wipe ? '0 : (miss && !err_q) ? tail_exp : first_exp_q;
        first_got_d = wipe ? '0 : (miss && !err_q) ? bus.pi_c : first_got_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            num_q       <= '0;
            issue_q     <= '0;
            pass_cnt_q  <= '0;
            err_cnt_q   <= '0;
            err_q       <= 1'b0;
            first_exp_q <= '0;
            first_got_q <= '0;
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            issue_q     <= issue_d;
            pass_cnt_q  <= pass_cnt_d;
            err_cnt_q   <= err_cnt_d;
            err_q       <= err_d;
            first_exp_q <= first_exp_d;
            first_got_q <= first_got_d;
        end
    end

    assign bus.po_pass_cnt  = pass_cnt_q;
    assign bus.po_err_cnt   = err_cnt_q;
    assign bus.po_err       = err_q;
    assign bus.po_first_exp = first_exp_q;
    assign bus.po_first_got = first_got_q;
    assign bus.po_busy      = state_q == RUN || state_q == DRAIN;
    assign bus.po_done      = state_q == DONE;
endmodule

// File: tb/tb_a_and_b_checker.sv
// tb_a_and_b_checker: directed checks of the a&b checker against a registered 1-cycle a&b reference.
module tb_a_and_b_checker;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] a, b, c_q, c, ovr;
    logic       ovr_en;
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    a_and_b_checker_if #(.DATA_W(8), .CNT_W(16)) b1 ();
    a_and_b_checker_if #(.DATA_W(8), .CNT_W(16)) b2 ();
    a_and_b_checker_if #(.DATA_W(8), .CNT_W(4))  b3 ();

    // reference DUT: one-cycle registered a&b, with an override to inject faults
    always @(posedge clk) c_q <= a & b;
    assign c = ovr_en ? ovr : c_q;

    assign b1.pi_a = a;
    assign b1.pi_b = b;
    assign b1.pi_c = c;
    assign b2.pi_a = a;
    assign b2.pi_b = b;
    assign b2.pi_c = c;
    assign b3.pi_a = a;
    assign b3.pi_b = b;
    assign b3.pi_c = c;

    a_and_b_checker #(.DATA_W(8), .LATENCY(1), .CNT_W(16)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    a_and_b_checker #(.DATA_W(8), .LATENCY(2), .CNT_W(16)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
    a_and_b_checker #(.DATA_W(8), .LATENCY(1), .CNT_W(4))  u3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    function automatic logic [63:0] o1();
        return 64'({b1.po_pass_cnt, b1.po_err_cnt, b1.po_err, b1.po_first_exp, b1.po_first_got, b1.po_busy, b1.po_done});
    endfunction
    function automatic logic [63:0] o2();
        return 64'({b2.po_pass_cnt, b2.po_err_cnt, b2.po_err, b2.po_first_exp, b2.po_first_got, b2.po_busy, b2.po_done});
    endfunction
    function automatic logic [63:0] o3();
        return 64'({b3.po_pass_cnt, b3.po_err_cnt, b3.po_err, b3.po_first_exp, b3.po_first_got, b3.po_busy, b3.po_done});
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // n-sample run on u1; faults override pi_c on the compares of samples f1 (0x1F) and f2 (0x00)
    task automatic run_b1(input int n, input int f1, input int f2, input logic [15:0] ep,
                          input logic [15:0] ee, input logic ef, input logic [7:0] fe, input logic [7:0] fg);
        b1.pi_num   = 16'(n);
        b1.pi_start = 1'b1;
        cyc();
        b1.pi_start = 1'b0;
        chk("run_busy", 64'(b1.po_busy), 64'(1));
        for (int k = 1; k <= n + 1; k++) begin
            a      = k == 4 ? 8'hFF : k == 7 ? 8'hF0 : 8'(k * 37 + 5);
            b      = k == 4 ? 8'h0F : k == 7 ? 8'h3C : 8'(k * 91 + 3);
            ovr_en = (k - 1 == f1) || (k - 1 == f2);
            ovr    = (k - 1 == f1) ? 8'h1F : 8'h00;
            cyc();
        end
        ovr_en = 1'b0;
        chk("run_done_busy", 64'({b1.po_done, b1.po_busy}), 64'(2'b10));
        chk("run_pass_cnt", 64'(b1.po_pass_cnt), 64'(ep));
        chk("run_err_cnt", 64'(b1.po_err_cnt), 64'(ee));
        chk("run_err", 64'(b1.po_err), 64'(ef));
        chk("run_first_exp", 64'(b1.po_first_exp), 64'(fe));
        chk("run_first_got", 64'(b1.po_first_got), 64'(fg));
    endtask

    initial begin
        rst_n  = 1'b0;
        a      = 8'h00;
        b      = 8'h00;
        ovr    = 8'h00;
        ovr_en = 1'b0;
        {b1.pi_start, b1.pi_clr, b1.pi_num} = '0;
        {b2.pi_start, b2.pi_clr, b2.pi_num} = '0;
        {b3.pi_start, b3.pi_clr, b3.pi_num} = '0;
        repeat (3) begin
            a = 8'($urandom);
            b = 8'($urandom);
            cyc();
        end
        chk("rst_b1", o1(), 64'(0));
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a      = 8'($urandom);
            b      = 8'($urandom);
            ovr    = 8'($urandom);
            ovr_en = 1'b1;
            cyc();
            chk("idle_b1", o1(), 64'(0));
            chk("idle_b2", o2(), 64'(0));
            chk("idle_b3", o3(), 64'(0));
        end
        ovr_en = 1'b0;

        run_b1(10, -1, -1, 16'd10, 16'd0, 1'b0, 8'h00, 8'h00);
        run_b1(10, 4, 7, 16'd8, 16'd2, 1'b1, 8'h0F, 8'h1F);

        // u2 expects 2 cycles against the 1-cycle reference; u3 free-runs into saturation
        b2.pi_num   = 16'd20;
        b2.pi_start = 1'b1;
        b3.pi_num   = 4'd0;
        b3.pi_start = 1'b1;
        cyc();
        b2.pi_start = 1'b0;
        b3.pi_start = 1'b0;
        for (int i = 0; i < 42; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            cyc();
        end
        chk("lat_done", 64'(b2.po_done), 64'(1));
        chk("lat_err", 64'(b2.po_err), 64'(1));
        chk("lat_err_nonzero", 64'(b2.po_err_cnt != 16'd0), 64'(1));
        chk("lat_total", 64'(32'(b2.po_pass_cnt) + 32'(b2.po_err_cnt)), 64'(20));
        chk("sat_pass", 64'(b3.po_pass_cnt), 64'(15));
        chk("sat_err_cnt", 64'(b3.po_err_cnt), 64'(0));
        chk("sat_busy_done", 64'({b3.po_busy, b3.po_done}), 64'(2'b10));
        b3.pi_clr   = 1'b1;
        b3.pi_start = 1'b1;
        cyc();
        b3.pi_clr   = 1'b0;
        b3.pi_start = 1'b0;
        chk("clr_b3", o3(), 64'(0));
        cyc();
        chk("clr_b3_idle", o3(), 64'(0));

        b1.pi_num   = 16'd10;
        b1.pi_start = 1'b1;
        cyc();
        b1.pi_start = 1'b0;
        repeat (4) begin
            a = 8'($urandom);
            b = 8'($urandom);
            cyc();
        end
        chk("abort_pre_busy", 64'(b1.po_busy), 64'(1));
        chk("abort_pre_pass", 64'(b1.po_pass_cnt), 64'(3));
        #2 rst_n = 1'b0;
        #1 chk("abort_async_b1", o1(), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run_b1(10, -1, -1, 16'd10, 16'd0, 1'b0, 8'h00, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/a_and_b_checker.md
Name: a_and_b_checker

Overview:
Synthesizable result checker sitting on the consuming end of the a_and_b_2 datapath. Samples the same pi_a/pi_b stimulus the DUT receives and computes the expected a&b. Delays that value by the DUT's pipeline latency and compares it against the DUT output each cycle. Reports pass/error counts, a sticky error flag and the first mismatch, for on-board self-test and simulation.

Parameters:
DATA_W, 8, width of a, b, c.
LATENCY, 1, DUT latency in clock cycles, legal 1..8. Inputs sampled at edge t are checked against pi_c sampled at edge t+LATENCY.
CNT_W, 16, width of the sample-count target and of the pass/error counters.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
pi_start  in  1  one-cycle pulse; starts a run from IDLE or DONE, ignored in RUN/DRAIN.
pi_clr  in  1  synchronous clear of counters, flags and FSM; returns to IDLE.
pi_num  in  CNT_W  samples per run, latched on pi_start; 0 = run until pi_clr.
pi_a  in  DATA_W  stimulus a, as driven to the DUT.
pi_b  in  DATA_W  stimulus b, as driven to the DUT.
pi_c  in  DATA_W  DUT output under check.
po_pass_cnt  out  CNT_W  matched comparisons, saturating.
po_err_cnt  out  CNT_W  mismatched comparisons, saturating.
po_err  out  1  sticky; set on first mismatch.
po_first_exp  out  DATA_W  expected value at first mismatch.
po_first_got  out  DATA_W  pi_c at first mismatch.
po_busy  out  1  high in RUN or DRAIN.
po_done  out  1  high in DONE.

Behaviour:
- Reset (rst_n low, asynchronous): FSM=IDLE. All outputs 0. Expected/valid pipeline cleared. Latched num and issue counter = 0.
- States:
  - IDLE: pi_start -> RUN; latch pi_num, clear counters, po_err, first_* and the issue counter.
  - RUN: each cycle push exp=pi_a&pi_b with valid=1 into a LATENCY-deep shift pipe; issue counter +1. When num!=0 and issue counter reaches num on this push -> DRAIN. When num=0, stay in RUN indefinitely.
  - DRAIN: push valid=0 entries; when no valid entry remains in the pipe -> DONE.
  - DONE: hold results; pi_start -> RUN with a fresh run (same clearing as from IDLE).
- Samples are taken only in RUN. The cycle pi_start is accepted does not sample; the first sample is the next edge.
- Compare stage: when pipe tail valid=1, compare tail exp with pi_c at that edge.
  - Equal: pass_cnt+1.
  - Unequal: err_cnt+1. If po_err was 0, capture first_exp/first_got and set po_err in the same edge.
- Counters saturate at 2^CNT_W-1 and never wrap. Sticky po_err and the first_* capture are unaffected by saturation.
- Latency: a mismatch at edge t+LATENCY is visible on outputs after that edge; registered, no combinational path from pi_c to outputs.
- pi_clr has priority over pi_start and over compares in the same cycle: the entire state returns to reset values synchronously.
- Reset asserted mid-run aborts immediately. No partial results are retained.
- pass_cnt+err_cnt == num at DONE when num < 2^CNT_W.

Decomposition:
- Shared package/header: DATA_W and CNT_W defaults, FSM state encodings (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2, DONE=2'd3), LATENCY_MAX=8.
- One sub-module: a_and_b_exp_pipe. Parameterized LATENCY-deep shift register of {valid, exp} with a flush input; the top holds the FSM, comparator and counters.

Test Plan:
- Reset/idle: hold rst_n=0 then release, no pi_start, random a/b/c -> all outputs 0, po_busy=0 throughout.
- Clean run: LATENCY=1, pi_num=10, pi_c driven by a correct registered a&b model -> po_done after the 10th compare, pass_cnt=10, err_cnt=0, po_err=0.
- Injected fault: as above, force pi_c=8'h1F on the compare for sample 4 whose a=8'hFF, b=8'h0F -> err_cnt=1, pass_cnt=9, po_err=1, first_exp=8'h0F, first_got=8'h1F. A second fault does not change first_*.
- Latency mismatch: LATENCY=2 against a 1-cycle DUT, random data, pi_num=20 -> err_cnt>0, po_err=1, pass_cnt+err_cnt=20.
- Saturation: CNT_W=4, pi_num=0, correct DUT for 40 cycles -> pass_cnt holds at 15, still in RUN; pi_clr -> all outputs 0, state IDLE next cycle.
- Abort: rst_n pulsed low mid-RUN with pi_num=10 -> outputs clear asynchronously. A new pi_start then completes a clean run with pass_cnt=10.
